// File: rtl/fetch_ctrl_if.sv
// Bus-side signal bundle of the fetch/sequencer block: w-bus input,
// ring state, instruction register view and the one-hot control word.
interface fetch_ctrl_if;
  logic [7:0] bus_in;
  logic [6:0] t_state;
  logic [7:0] ir;
  logic [3:0] ir_addr;
  logic       halt;
  logic       cp;
  logic       ep;
  logic       lm;
  logic       epr;
  logic       li;
  logic       ei;
  logic       la;
  logic       ea;
  logic       lb;
  logic       su;
  logic       eu;
  logic       lo;

  // Sequencer side: samples the bus, drives state and controls.
  modport master (
    input  bus_in,
    output t_state, ir, ir_addr, halt,
    output cp, ep, lm, epr, li, ei, la, ea, lb, su, eu, lo
  );

  // Datapath side: drives the bus, consumes state and controls.
  modport slave (
    output bus_in,
    input  t_state, ir, ir_addr, halt,
    input  cp, ep, lm, epr, li, ei, la, ea, lb, su, eu, lo
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction register and T-state ring sequencer for the 8-bit CPU.
// The ring is one-hot (T1..T7) with all-zero meaning HALT. Controls are a
// combinational decode of the registered ring and IR, forced low in reset.
module fetch_ctrl #(
  parameter int RING_W = 7,
  parameter int OP_W   = 4
) (
  input logic        clk,
  input logic        rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [RING_W-1:0] {
    S_HALT = 7'b0000000,
    S_T1   = 7'b0000001,
    S_T2   = 7'b0000010,
    S_T3   = 7'b0000100,
    S_T4   = 7'b0001000,
    S_T5   = 7'b0010000,
    S_T6   = 7'b0100000,
    S_T7   = 7'b1000000
  } state_t;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0100;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  // Bit positions inside the packed control word.
  localparam int CP  = 11;
  localparam int EP  = 10;
  localparam int LM  = 9;
  localparam int EPR = 8;
  localparam int LI  = 7;
  localparam int EI  = 6;
  localparam int LA  = 5;
  localparam int EA  = 4;
  localparam int LB  = 3;
  localparam int SU  = 2;
  localparam int EU  = 1;
  localparam int LO  = 0;

  state_t           state_r;
  state_t           state_nxt;
  logic [7:0]       ir_r;
  logic [OP_W-1:0]  op_s;
  logic [11:0]      ctrl_s;
  logic [11:0]      ctrl_out_s;

  assign op_s = ir_r[7 -: OP_W];

  // Ring register: reset lands on T1, otherwise follow the decoded next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_T1;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Instruction register: loaded from the w bus only in the T3 load cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_r <= 8'h00;
    end else if (ctrl_s[LI]) begin
      ir_r <= bus.bus_in;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Next ring position, including early return to T1 and entry into HALT.
  always_comb begin
    state_nxt = S_T1;
    case (state_r)
      S_T1: state_nxt = S_T2;
      S_T2: state_nxt = S_T3;
      S_T3: state_nxt = S_T4;
      S_T4: begin
        case (op_s)
          OP_LDA, OP_ADD, OP_SUB: state_nxt = S_T5;
          OP_HLT:                 state_nxt = S_HALT;
          default:                state_nxt = S_T1;
        endcase
      end
      S_T5: state_nxt = S_T6;
      S_T6: begin
        case (op_s)
          OP_ADD, OP_SUB: state_nxt = S_T7;
          default:        state_nxt = S_T1;
        endcase
      end
      S_T7:   state_nxt = S_T1;
      S_HALT: state_nxt = S_HALT;
      // Non-one-hot ring values fall back to T1.
      default: state_nxt = S_T1;
    endcase
  end

  // Control word decode; T5 is the idle cycle ahead of the registered ROM read.
  always_comb begin
    ctrl_s = 12'h000;
    case (state_r)
      S_T1: begin
        ctrl_s[EP] = 1'b1;
        ctrl_s[LM] = 1'b1;
      end
      S_T2: ctrl_s[CP] = 1'b1;
      S_T3: begin
        ctrl_s[EPR] = 1'b1;
        ctrl_s[LI]  = 1'b1;
      end
      S_T4: begin
        case (op_s)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl_s[EI] = 1'b1;
            ctrl_s[LM] = 1'b1;
          end
          OP_OUT: begin
            ctrl_s[EA] = 1'b1;
            ctrl_s[LO] = 1'b1;
          end
          default: ctrl_s = 12'h000;
        endcase
      end
      S_T6: begin
        case (op_s)
          OP_LDA: begin
            ctrl_s[EPR] = 1'b1;
            ctrl_s[LA]  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_s[EPR] = 1'b1;
            ctrl_s[LB]  = 1'b1;
          end
          default: ctrl_s = 12'h000;
        endcase
      end
      S_T7: begin
        ctrl_s[EU] = 1'b1;
        ctrl_s[LA] = 1'b1;
        ctrl_s[SU] = (op_s == OP_SUB) ? 1'b1 : 1'b0;
      end
      default: ctrl_s = 12'h000;
    endcase
  end

  // Reset masks every control so nothing loads on the reset edge.
  always_comb begin
    if (rst) begin
      ctrl_out_s = 12'h000;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign bus.t_state = state_r;
  assign bus.ir      = ir_r;
  assign bus.ir_addr = ir_r[3:0];
  assign bus.halt    = (state_r == S_HALT) ? 1'b1 : 1'b0;
  assign bus.cp      = ctrl_out_s[CP];
  assign bus.ep      = ctrl_out_s[EP];
  assign bus.lm      = ctrl_out_s[LM];
  assign bus.epr     = ctrl_out_s[EPR];
  assign bus.li      = ctrl_out_s[LI];
  assign bus.ei      = ctrl_out_s[EI];
  assign bus.la      = ctrl_out_s[LA];
  assign bus.ea      = ctrl_out_s[EA];
  assign bus.lb      = ctrl_out_s[LB];
  assign bus.su      = ctrl_out_s[SU];
  assign bus.eu      = ctrl_out_s[EU];
  assign bus.lo      = ctrl_out_s[LO];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: one vector per clock cycle,
// followed by a hand-written SUB sequence that measures instruction length.
module tb_fetch_ctrl;

  logic clk;
  logic rst;

  fetch_ctrl_if bus_if ();

  fetch_ctrl #(.RING_W(7), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word packing: {cp,ep,lm,epr,li,ei,la,ea,lb,su,eu,lo}
  localparam logic [11:0] C0    = 12'h000;
  localparam logic [11:0] CT1   = 12'h600;
  localparam logic [11:0] CT2   = 12'h800;
  localparam logic [11:0] CT3   = 12'h180;
  localparam logic [11:0] CMAR  = 12'h240;
  localparam logic [11:0] CLDA  = 12'h120;
  localparam logic [11:0] CLDB  = 12'h108;
  localparam logic [11:0] CADD  = 12'h022;
  localparam logic [11:0] CSUB  = 12'h026;
  localparam logic [11:0] COUT  = 12'h011;

  localparam logic [6:0] TH = 7'h00;
  localparam logic [6:0] T1 = 7'h01;
  localparam logic [6:0] T2 = 7'h02;
  localparam logic [6:0] T3 = 7'h04;
  localparam logic [6:0] T4 = 7'h08;
  localparam logic [6:0] T5 = 7'h10;
  localparam logic [6:0] T6 = 7'h20;
  localparam logic [6:0] T7 = 7'h40;

  typedef struct {
    logic       rst;
    logic [7:0] bus;
    logic [6:0] t;
    logic [7:0] ir;
    logic       halt;
    logic [11:0] ctrl;
  } vec_t;

  vec_t vecs[$];
  int   tests;
  int   fails;

  logic [11:0] act_ctrl;
  logic [4:0]  drivers;

  assign act_ctrl = {bus_if.cp, bus_if.ep, bus_if.lm, bus_if.epr, bus_if.li, bus_if.ei,
                     bus_if.la, bus_if.ea, bus_if.lb, bus_if.su, bus_if.eu, bus_if.lo};
  assign drivers  = {bus_if.ep, bus_if.epr, bus_if.ei, bus_if.ea, bus_if.eu};

  task automatic add(input logic r, input logic [7:0] b, input logic [6:0] t,
                     input logic [7:0] ir, input logic h, input logic [11:0] c);
    vec_t v;
    v.rst = r; v.bus = b; v.t = t; v.ir = ir; v.halt = h; v.ctrl = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_drivers(input string name);
    tests++;
    if ($countones(drivers) > 1) begin
      fails++;
      $display("FAIL %s bus_drivers: got %b, expected at most one high", name, drivers);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic su_seen;
    tests = 0;
    fails = 0;

    // Reset, then LDA
    add(1'b1, 8'hAA, T1, 8'h00, 1'b0, C0);
    add(1'b0, 8'hAA, T1, 8'h00, 1'b0, CT1);
    add(1'b0, 8'hAA, T2, 8'h00, 1'b0, CT2);
    add(1'b0, 8'h0F, T3, 8'h00, 1'b0, CT3);
    add(1'b0, 8'hAA, T4, 8'h0F, 1'b0, CMAR);
    add(1'b0, 8'hAA, T5, 8'h0F, 1'b0, C0);
    add(1'b0, 8'hAA, T6, 8'h0F, 1'b0, CLDA);
    // ADD
    add(1'b0, 8'hAA, T1, 8'h0F, 1'b0, CT1);
    add(1'b0, 8'hAA, T2, 8'h0F, 1'b0, CT2);
    add(1'b0, 8'h3E, T3, 8'h0F, 1'b0, CT3);
    add(1'b0, 8'hAA, T4, 8'h3E, 1'b0, CMAR);
    add(1'b0, 8'hAA, T5, 8'h3E, 1'b0, C0);
    add(1'b0, 8'hAA, T6, 8'h3E, 1'b0, CLDB);
    add(1'b0, 8'hAA, T7, 8'h3E, 1'b0, CADD);
    // SUB
    add(1'b0, 8'hAA, T1, 8'h3E, 1'b0, CT1);
    add(1'b0, 8'hAA, T2, 8'h3E, 1'b0, CT2);
    add(1'b0, 8'h4E, T3, 8'h3E, 1'b0, CT3);
    add(1'b0, 8'hAA, T4, 8'h4E, 1'b0, CMAR);
    add(1'b0, 8'hAA, T5, 8'h4E, 1'b0, C0);
    add(1'b0, 8'hAA, T6, 8'h4E, 1'b0, CLDB);
    add(1'b0, 8'hAA, T7, 8'h4E, 1'b0, CSUB);
    // OUT
    add(1'b0, 8'hAA, T1, 8'h4E, 1'b0, CT1);
    add(1'b0, 8'hAA, T2, 8'h4E, 1'b0, CT2);
    add(1'b0, 8'hE0, T3, 8'h4E, 1'b0, CT3);
    add(1'b0, 8'hAA, T4, 8'hE0, 1'b0, COUT);
    // NOP
    add(1'b0, 8'hAA, T1, 8'hE0, 1'b0, CT1);
    add(1'b0, 8'hAA, T2, 8'hE0, 1'b0, CT2);
    add(1'b0, 8'h70, T3, 8'hE0, 1'b0, CT3);
    add(1'b0, 8'hAA, T4, 8'h70, 1'b0, C0);
    // HLT
    add(1'b0, 8'hAA, T1, 8'h70, 1'b0, CT1);
    add(1'b0, 8'hAA, T2, 8'h70, 1'b0, CT2);
    add(1'b0, 8'hF0, T3, 8'h70, 1'b0, CT3);
    add(1'b0, 8'hAA, T4, 8'hF0, 1'b0, C0);
    for (int k = 0; k < 20; k++) begin
      add(1'b0, (k % 2 == 0) ? 8'h3E : 8'hF5, TH, 8'hF0, 1'b1, C0);
    end
    add(1'b1, 8'hAA, TH, 8'hF0, 1'b1, C0);
    // Restart, LDA aborted by reset in T6
    add(1'b0, 8'hAA, T1, 8'h00, 1'b0, CT1);
    add(1'b0, 8'hAA, T2, 8'h00, 1'b0, CT2);
    add(1'b0, 8'h0F, T3, 8'h00, 1'b0, CT3);
    add(1'b0, 8'hAA, T4, 8'h0F, 1'b0, CMAR);
    add(1'b0, 8'hAA, T5, 8'h0F, 1'b0, C0);
    add(1'b1, 8'hAA, T6, 8'h0F, 1'b0, C0);
    add(1'b0, 8'hAA, T1, 8'h00, 1'b0, CT1);
    add(1'b0, 8'hAA, T2, 8'h00, 1'b0, CT2);

    rst = 1'b1;
    bus_if.bus_in = 8'h00;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      bus_if.bus_in = vecs[i].bus;
      #1;
      chk($sformatf("v%0d t_state", i), {25'd0, bus_if.t_state}, {25'd0, vecs[i].t});
      chk($sformatf("v%0d ir", i), {24'd0, bus_if.ir}, {24'd0, vecs[i].ir});
      chk($sformatf("v%0d ir_addr", i), {28'd0, bus_if.ir_addr}, {28'd0, vecs[i].ir[3:0]});
      chk($sformatf("v%0d halt", i), {31'd0, bus_if.halt}, {31'd0, vecs[i].halt});
      chk($sformatf("v%0d ctrl", i), {20'd0, act_ctrl}, {20'd0, vecs[i].ctrl});
      chk_drivers($sformatf("v%0d", i));
      tick();
    end

    // Hand-written: SUB after a reset pulse, measure T1-to-T1 length and su in T7
    rst = 1'b1;
    bus_if.bus_in = 8'h4E;
    #1;
    chk("seq rst ctrl", {20'd0, act_ctrl}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("seq t1", {25'd0, bus_if.t_state}, {25'd0, T1});
    n = 0;
    su_seen = 1'b0;
    do begin
      tick();
      n++;
      chk_drivers($sformatf("seq c%0d", n));
      if (bus_if.t_state == T7 && bus_if.su == 1'b1) su_seen = 1'b1;
    end while (bus_if.t_state != T1 && n < 20);
    chk("seq sub_len", n, 32'd7);
    chk("seq sub_su", {31'd0, su_seen}, 32'd1);
    chk("seq ir", {24'd0, bus_if.ir}, 32'h4E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction register plus T-state sequencer for the 8-bit CPU. It sits directly downstream of the program ROM. During fetch it asserts the ROM output enable (epr) and latches the 8-bit instruction from the w bus. It then decodes the opcode and drives the one-hot control word for PC, MAR, accumulator, B register, ALU and output register across T-states T1..T7.

Parameters:
RING_W, 7, number of T-states in the ring counter (T1..T7).
OP_W, 4, opcode width (upper nibble of the instruction).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
bus_in  in  8  w bus value; sampled into IR when li=1
t_state  out  7  one-hot ring state (bit0=T1 ... bit6=T7); all-zero in HALT
ir  out  8  instruction register contents
ir_addr  out  4  IR operand nibble, ir[3:0]; top level places it on the bus when ei=1
halt  out  1  CPU stopped
cp  out  1  PC increment
ep  out  1  PC drives bus
lm  out  1  load MAR
epr  out  1  program ROM drives bus
li  out  1  load IR
ei  out  1  IR operand drives bus
la  out  1  load accumulator
ea  out  1  accumulator drives bus
lb  out  1  load B register
su  out  1  ALU subtract (0 = add)
eu  out  1  ALU result drives bus
lo  out  1  load output register

Behaviour:
- Opcodes are ir[7:4]: LDA=0000, ADD=0011, SUB=0100, OUT=1110, HLT=1111. All others are NOP.
- Reset on the clock edge with rst=1: t_state=T1, ir=0x00, halt=0.
- While rst=1, every control output is forced to 0. Reset asserted mid-instruction aborts the instruction; no partial load occurs after the reset edge.
- Control outputs are combinational decode of the registered t_state and ir. At most one bus driver (ep, epr, ei, ea, eu) is high in any cycle.
- The ROM registers its address, so ROM data is valid one cycle after the MAR load. Each epr cycle is therefore preceded by one idle cycle.
- Fetch, all opcodes:
  - T1: ep, lm.
  - T2: cp.
  - T3: epr, li. IR captures bus_in at the end of T3.
- Execute, decoded from ir:
  - LDA: T4 ei, lm. T5 idle. T6 epr, la. Then T1.
  - ADD: T4 ei, lm. T5 idle. T6 epr, lb. T7 eu, la, su=0. Then T1.
  - SUB: same as ADD, with su=1 in T7.
  - OUT: T4 ea, lo. Then T1.
  - NOP: T4 idle. Then T1.
  - HLT: at the end of T4 the block enters HALT. In HALT: halt=1, t_state=0, all controls 0, IR frozen, bus_in ignored. Only rst exits HALT.
- Ring rules:
  - The ring advances one position per clock.
  - Early return to T1 follows the instruction end listed above.
  - T7 always returns to T1.
- Instruction lengths: LDA 6 cycles, ADD/SUB 7, OUT/NOP 4.
- IR is written only in T3. ir and ir_addr are stable from T4 until the next T3.
- No illegal ring states are reachable. Any non-one-hot t_state recovers to T1 on the next edge.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, then release.
   - During rst: all control outputs 0.
   - First cycle after release: t_state=0000001, ep=lm=1, ir=0x00, halt=0.
   - Second cycle: t_state=0000010, cp=1.
2. LDA: bus_in=0x0F in T3.
   - ir=0x0F, ir_addr=0xF.
   - T4: ei=lm=1. T5: all controls 0. T6: epr=la=1.
   - T1 again 6 cycles after the previous T1.
3. ADD then SUB:
   - ADD (bus_in=0x3E in T3): T6 epr=lb=1; T7 eu=la=1, su=0.
   - SUB (bus_in=0x4E in T3): T7 su=1.
   - Each returns to T1 after 7 cycles.
4. OUT and NOP:
   - OUT (bus_in=0xE0): T4 ea=lo=1, T1 follows.
   - NOP (bus_in=0x70): T4 all controls 0, T1 follows.
   - Both instructions take 4 cycles.
5. HLT: bus_in=0xF0 in T3.
   - From the cycle after T4: halt=1, t_state=0, all controls 0 for 20 cycles, even with bus_in toggling.
   - After rst pulse: T1 with halt=0.
6. Mid-instruction reset: assert rst in T6 of LDA.
   - la is not asserted on that edge (held 0 while rst=1).
   - Next cycle: t_state=T1, ir=0x00.
   - Bench checks that at most one bus driver is high in every cycle of scenarios 1-6.
